// File: rtl/sdrc_arb_pkg.sv
// Shared definitions for the SDRAM application-port arbiter: FSM encoding and
// a reference round-robin owner selection usable by other arbiters.
package sdrc_arb_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] REQ  = 3'd1;
   localparam logic [2:0] WR   = 3'd2;
   localparam logic [2:0] RD   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam int MAX_REQ = 8;

   // Scans from ptr upward with wrap at n; the lowest distance from ptr wins.
   function automatic logic [MAX_REQ-1:0] next_rr_owner(input logic [MAX_REQ-1:0] req,
                                                        input logic [2:0] ptr,
                                                        input int n);
      logic [MAX_REQ-1:0] gnt;
      int idx;
      gnt = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = (int'(ptr) + k) % n;
            if (req[3'(idx)]) begin
               gnt = '0;
               gnt[3'(idx)] = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// isolate the lowest set bit, then rotate the one-hot result back.
module sdrc_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic [NREQ-1:0] rot;
   logic [NREQ-1:0] first;

   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[PW'(i)] = req[PW'((i + int'(ptr)) % NREQ)];
      end
   end

   assign first = rot & (~rot + NREQ'(1));

   always_comb begin
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant[PW'((i + int'(ptr)) % NREQ)] = first[PW'(i)];
      end
   end

endmodule

// File: rtl/sdrc_req_arbiter.sv
// Round-robin owner of the single sdrc_core application port; one transfer
// is outstanding at a time and the grant is held until its last data beat.
module sdrc_req_arbiter
   import sdrc_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int APP_AW = 26,
   parameter int DW     = 32,
   parameter int BL     = 9
) (
   input  logic                   sdram_clk,
   input  logic                   sdram_resetn,
   input  logic                   sdr_init_done,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ*APP_AW-1:0] req_addr_i,
   input  logic [NREQ*BL-1:0]     req_len_i,
   input  logic [NREQ-1:0]        req_wr_n_i,
   output logic [NREQ-1:0]        req_ack_o,
   input  logic [NREQ*DW-1:0]     wr_data_i,
   input  logic [NREQ*DW/8-1:0]   wr_en_n_i,
   output logic [NREQ-1:0]        wr_next_o,
   output logic [DW-1:0]          rd_data_o,
   output logic [NREQ-1:0]        rd_valid_o,
   output logic [NREQ-1:0]        last_rd_o,
   output logic [NREQ-1:0]        grant_o,
   output logic                   app_req,
   output logic [APP_AW-1:0]      app_req_addr,
   output logic [BL-1:0]          app_req_len,
   output logic                   app_req_wr_n,
   input  logic                   app_req_ack,
   output logic [DW-1:0]          app_wr_data,
   output logic [DW/8-1:0]        app_wr_en_n,
   input  logic                   app_wr_next_req,
   input  logic [DW-1:0]          app_rd_data,
   input  logic                   app_rd_valid,
   input  logic                   app_last_rd
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = DW / 8;

   logic [2:0]      state;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   ptr;
   logic [BL-1:0]   beat_cnt;
   logic [NREQ-1:0] pick;
   logic [PW-1:0]   pick_idx;
   logic [BL-1:0]   pick_len;
   logic            sim_err;

   sdrc_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req   (req_i),
      .ptr   (ptr),
      .grant (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = PW'(i);
      end
   end

   assign pick_len = req_len_i[int'(pick_idx)*BL +: BL];

   // A zero length would never terminate the beat counter, so it becomes one word.
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state        <= IDLE;
         grant        <= '0;
         owner        <= '0;
         ptr          <= '0;
         beat_cnt     <= '0;
         app_req      <= 1'b0;
         app_req_addr <= '0;
         app_req_len  <= '0;
         app_req_wr_n <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sdr_init_done && (|req_i)) begin
                  grant        <= pick;
                  owner        <= pick_idx;
                  app_req      <= 1'b1;
                  app_req_addr <= req_addr_i[int'(pick_idx)*APP_AW +: APP_AW];
                  app_req_len  <= (pick_len == '0) ? BL'(1) : pick_len;
                  app_req_wr_n <= req_wr_n_i[pick_idx];
                  state        <= REQ;
               end
            end
            REQ: begin
               if (app_req_ack) begin
                  app_req  <= 1'b0;
                  beat_cnt <= app_req_len;
                  state    <= app_req_wr_n ? RD : WR;
               end
            end
            WR: begin
               if (app_wr_next_req) begin
                  beat_cnt <= beat_cnt - BL'(1);
                  if (beat_cnt == BL'(1)) state <= DONE;
               end
            end
            RD: begin
               if (app_rd_valid && app_last_rd) state <= DONE;
            end
            DONE: begin
               grant <= '0;
               ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake and data steering follow the registered owner, so only the
   // granted requester ever sees a strobe.
   always_comb begin
      req_ack_o   = '0;
      wr_next_o   = '0;
      rd_valid_o  = '0;
      last_rd_o   = '0;
      app_wr_data = '0;
      app_wr_en_n = '1;
      case (state)
         REQ: req_ack_o = grant & {NREQ{app_req_ack}};
         WR: begin
            app_wr_data = wr_data_i[int'(owner)*DW +: DW];
            app_wr_en_n = wr_en_n_i[int'(owner)*BW +: BW];
            wr_next_o   = grant & {NREQ{app_wr_next_req}};
         end
         RD: begin
            rd_valid_o = grant & {NREQ{app_rd_valid}};
            last_rd_o  = grant & {NREQ{app_rd_valid & app_last_rd}};
         end
         default: ;
      endcase
   end

   assign rd_data_o = app_rd_data;
   assign grant_o   = grant;

   // Read beats outside RD have no owner and are dropped.
   assign sim_err = app_rd_valid && (state != RD);
   no_stray_rd: assert property (@(posedge sdram_clk) disable iff (!sdram_resetn) !sim_err);

endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// Directed-plus-random bench for sdrc_req_arbiter; the bench plays both the
// requesters and the SDRAM controller and predicts owners by a plain scan.
module tb_sdrc_req_arbiter;

   localparam int NREQ   = 4;
   localparam int APP_AW = 26;
   localparam int DW     = 32;
   localparam int BL     = 9;
   localparam int BW     = DW / 8;

   logic                   sdram_clk = 1'b0;
   logic                   sdram_resetn = 1'b0;
   logic                   sdr_init_done = 1'b0;
   logic [NREQ-1:0]        req_i = '0;
   logic [NREQ*APP_AW-1:0] req_addr_i = '0;
   logic [NREQ*BL-1:0]     req_len_i = '0;
   logic [NREQ-1:0]        req_wr_n_i = '0;
   logic [NREQ-1:0]        req_ack_o;
   logic [NREQ*DW-1:0]     wr_data_i = '0;
   logic [NREQ*BW-1:0]     wr_en_n_i = '1;
   logic [NREQ-1:0]        wr_next_o;
   logic [DW-1:0]          rd_data_o;
   logic [NREQ-1:0]        rd_valid_o;
   logic [NREQ-1:0]        last_rd_o;
   logic [NREQ-1:0]        grant_o;
   logic                   app_req;
   logic [APP_AW-1:0]      app_req_addr;
   logic [BL-1:0]          app_req_len;
   logic                   app_req_wr_n;
   logic                   app_req_ack = 1'b0;
   logic [DW-1:0]          app_wr_data;
   logic [BW-1:0]          app_wr_en_n;
   logic                   app_wr_next_req = 1'b0;
   logic [DW-1:0]          app_rd_data = '0;
   logic                   app_rd_valid = 1'b0;
   logic                   app_last_rd = 1'b0;

   int total = 0;
   int bad   = 0;
   int ptr_m = 0;

   sdrc_req_arbiter #(.NREQ(NREQ), .APP_AW(APP_AW), .DW(DW), .BL(BL)) dut (
      .sdram_clk       (sdram_clk),
      .sdram_resetn    (sdram_resetn),
      .sdr_init_done   (sdr_init_done),
      .req_i           (req_i),
      .req_addr_i      (req_addr_i),
      .req_len_i       (req_len_i),
      .req_wr_n_i      (req_wr_n_i),
      .req_ack_o       (req_ack_o),
      .wr_data_i       (wr_data_i),
      .wr_en_n_i       (wr_en_n_i),
      .wr_next_o       (wr_next_o),
      .rd_data_o       (rd_data_o),
      .rd_valid_o      (rd_valid_o),
      .last_rd_o       (last_rd_o),
      .grant_o         (grant_o),
      .app_req         (app_req),
      .app_req_addr    (app_req_addr),
      .app_req_len     (app_req_len),
      .app_req_wr_n    (app_req_wr_n),
      .app_req_ack     (app_req_ack),
      .app_wr_data     (app_wr_data),
      .app_wr_en_n     (app_wr_en_n),
      .app_wr_next_req (app_wr_next_req),
      .app_rd_data     (app_rd_data),
      .app_rd_valid    (app_rd_valid),
      .app_last_rd     (app_last_rd)
   );

   always #5 sdram_clk = ~sdram_clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge sdram_clk);
      #2;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Owner = first requesting index met when walking ptr, ptr+1, ... modulo NREQ.
   function automatic int model_winner(input logic [NREQ-1:0] reqv, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (reqv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic reset_dut();
      sdram_resetn    = 1'b0;
      req_i           = '0;
      app_req_ack     = 1'b0;
      app_wr_next_req = 1'b0;
      app_rd_valid    = 1'b0;
      app_last_rd     = 1'b0;
      tick();
      #1;
      check_output("rst_app_req", app_req, 0);
      check_output("rst_addr", app_req_addr, 0);
      check_output("rst_len", app_req_len, 0);
      check_output("rst_wr_n", app_req_wr_n, 0);
      check_output("rst_wr_en_n", app_wr_en_n, {BW{1'b1}});
      check_output("rst_wr_data", app_wr_data, 0);
      check_output("rst_grant", grant_o, 0);
      check_output("rst_strobes", {req_ack_o, wr_next_o, rd_valid_o, last_rd_o}, 0);
      tick();
      sdram_resetn = 1'b1;
      ptr_m = 0;
      #1;
   endtask

   // One complete transfer: the bench is every requester and the controller.
   task automatic apply_stimulus(input logic [NREQ-1:0] reqv, input logic [APP_AW-1:0] addr,
                                 input int len, input logic wr_n, input int ack_dly,
                                 input int abort_beats, input int dbase, input bit drop_init);
      int win, elen, waited, seen;
      logic [DW-1:0] wd, rdv;
      logic [BW-1:0] we;
      win  = model_winner(reqv, ptr_m);
      elen = (len == 0) ? 1 : len;
      for (int r = 0; r < NREQ; r++) begin
         req_addr_i[r*APP_AW +: APP_AW] = APP_AW'($urandom);
         req_len_i[r*BL +: BL]          = BL'($urandom_range(0, 7));
         req_wr_n_i[r]                  = 1'($urandom_range(0, 1));
         wr_data_i[r*DW +: DW]          = $urandom;
         wr_en_n_i[r*BW +: BW]          = BW'($urandom);
      end
      req_addr_i[win*APP_AW +: APP_AW] = addr;
      req_len_i[win*BL +: BL]          = BL'(len);
      req_wr_n_i[win]                  = wr_n;
      req_i = reqv;
      waited = 0;
      do begin
         tick();
         #1;
         waited++;
      end while (app_req !== 1'b1 && waited < 40);
      check_output("grant_latency", 64'(waited), 64'd1);
      if (app_req !== 1'b1) begin
         req_i = '0;
         return;
      end
      check_output("grant", grant_o, onehot(win));
      check_output("req_addr", app_req_addr, addr);
      check_output("req_len", app_req_len, 64'(elen));
      check_output("req_wr_n", app_req_wr_n, wr_n);
      req_addr_i[win*APP_AW +: APP_AW] = APP_AW'($urandom);
      req_len_i[win*BL +: BL]          = BL'($urandom);
      for (int i = 1; i < ack_dly; i++) begin
         check_output("early_ack", req_ack_o, 0);
         tick();
         #1;
         check_output("req_hold", app_req, 1);
      end
      app_req_ack = 1'b1;
      #1;
      check_output("req_ack", req_ack_o, onehot(win));
      check_output("addr_held", app_req_addr, addr);
      tick();
      app_req_ack = 1'b0;
      req_i = NREQ'($urandom) & ~onehot(win);
      if (drop_init) sdr_init_done = 1'b0;
      #1;
      check_output("req_cleared", app_req, 0);
      check_output("ack_pulse", req_ack_o, 0);
      if (!wr_n) begin
         for (int b = 0; b < elen; b++) begin
            wd = (dbase >= 0) ? DW'(dbase + b) : DW'($urandom);
            we = (dbase >= 0) ? '0 : BW'($urandom);
            wr_data_i[win*DW +: DW] = wd;
            wr_en_n_i[win*BW +: BW] = we;
            if ($urandom_range(0, 2) == 0) begin
               #1;
               check_output("wr_stall", wr_next_o, 0);
               tick();
            end
            app_wr_next_req = 1'b1;
            #1;
            check_output("wr_next", wr_next_o, onehot(win));
            check_output("wr_data", app_wr_data, wd);
            check_output("wr_en_n", app_wr_en_n, we);
            tick();
            app_wr_next_req = 1'b0;
            #1;
            if (b + 1 == abort_beats) begin
               app_wr_next_req = 1'b1;
               sdram_resetn = 1'b0;
               #1;
               check_output("abort_app_req", app_req, 0);
               check_output("abort_grant", grant_o, 0);
               check_output("abort_wr_next", wr_next_o, 0);
               check_output("abort_wr_en_n", app_wr_en_n, {BW{1'b1}});
               check_output("abort_wr_data", app_wr_data, 0);
               check_output("abort_req_regs", {app_req_addr, app_req_len, app_req_wr_n}, 0);
               tick();
               sdram_resetn    = 1'b1;
               app_wr_next_req = 1'b0;
               req_i           = '0;
               ptr_m           = 0;
               #1;
               return;
            end
         end
      end else begin
         for (int b = 0; b < elen; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               app_last_rd = 1'b1;
               #1;
               check_output("rd_stall_valid", rd_valid_o, 0);
               check_output("rd_stall_last", last_rd_o, 0);
               tick();
            end
            rdv = $urandom;
            app_rd_data  = rdv;
            app_rd_valid = 1'b1;
            app_last_rd  = (b == elen - 1);
            #1;
            check_output("rd_valid", rd_valid_o, onehot(win));
            check_output("last_rd", last_rd_o, (b == elen - 1) ? onehot(win) : '0);
            check_output("rd_data", rd_data_o, rdv);
            tick();
            app_rd_valid = 1'b0;
            app_last_rd  = 1'b0;
            #1;
         end
      end
      check_output("grant_in_done", grant_o, onehot(win));
      check_output("wr_en_n_idle", app_wr_en_n, {BW{1'b1}});
      req_i = '0;
      tick();
      #1;
      check_output("grant_clear", grant_o, 0);
      ptr_m = (win + 1) % NREQ;
      if (drop_init) begin
         req_i = '1;
         seen = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (app_req) seen++;
         end
         check_output("init_low_hold", 64'(seen), 0);
         req_i = '0;
         sdr_init_done = 1'b1;
      end
   endtask

   initial begin
      int seen;
      $display("[TB] start");
      reset_dut();
      sdr_init_done = 1'b1;

      for (int t = 0; t < 6; t++) apply_stimulus(4'b1111, APP_AW'(26'h40 + t), 1, 1'b0, 1, -1, -1, 1'b0);

      apply_stimulus(4'b0001, APP_AW'(26'h000100), 4, 1'b0, 3, -1, 32'hA0, 1'b0);
      apply_stimulus(4'b0100, APP_AW'(26'h002000), 8, 1'b1, 2, -1, -1, 1'b0);

      sdr_init_done = 1'b0;
      req_i = 4'b0010;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         #1;
         if (app_req) seen++;
      end
      check_output("init_gate", 64'(seen), 0);
      sdr_init_done = 1'b1;
      apply_stimulus(4'b0010, APP_AW'(26'h0000F0), 2, 1'b0, 1, -1, -1, 1'b0);

      apply_stimulus(4'b1000, APP_AW'(26'h3FFFFFF), 0, 1'b1, 1, -1, -1, 1'b0);

      for (int t = 0; t < 25; t++) begin
         apply_stimulus(NREQ'($urandom_range(1, 15)), APP_AW'($urandom), $urandom_range(0, 6),
                        1'($urandom_range(0, 1)), $urandom_range(1, 4), -1, -1, 1'b0);
      end

      apply_stimulus(4'b0010, APP_AW'(26'h1234), 3, 1'b1, 2, -1, -1, 1'b1);

      apply_stimulus(4'b0100, APP_AW'(26'h55), 1, 1'b0, 1, -1, -1, 1'b0);
      apply_stimulus(4'b1000, APP_AW'(26'h77), 4, 1'b0, 2, 2, -1, 1'b0);
      apply_stimulus(4'b1111, APP_AW'(26'h99), 2, 1'b0, 1, -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
